// File: rtl/vram_wb_arbiter.sv
// Two-master round-robin arbiter in front of the VRAM CPU port.
// A grant is held for one transfer; a watchdog aborts a transfer that never gets an ack.
module vram_wb_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  input  logic          m0_we_i,
  input  logic          m0_stb_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  input  logic          m1_we_i,
  input  logic          m1_stb_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  output logic          s_we_o,
  output logic          s_stb_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  output logic [1:0]    gnt_o
);

  // Handshake: a master holds stb until it sees ack or err; ack completes the
  // transfer in the cycle it is high, dropping stb early abandons the transfer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       last;
  logic [7:0] wdog;
  logic       err0;
  logic       err1;
  logic       own_stb;

  assign own_stb = (state == OWN1) ? m1_stb_i : m0_stb_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      wdog  <= 8'd0;
      err0  <= 1'b0;
      err1  <= 1'b0;
    end else begin
      err0 <= 1'b0;
      err1 <= 1'b0;
      case (state)
        IDLE: begin
          wdog <= 8'd0;
          // On a tie the master that was not served last wins.
          if (m0_stb_i && (!m1_stb_i || last)) state <= OWN0;
          else if (m1_stb_i)                   state <= OWN1;
        end
        OWN0, OWN1: begin
          if (own_stb && s_ack_i) begin
            state <= IDLE;
            last  <= (state == OWN1);
            wdog  <= 8'd0;
          end else if (!own_stb) begin
            state <= IDLE;
            last  <= (state == OWN1);
            wdog  <= 8'd0;
          end else if (wdog == WD_LAST) begin
            state <= IDLE;
            last  <= (state == OWN1);
            wdog  <= 8'd0;
            err0  <= (state == OWN0);
            err1  <= (state == OWN1);
          end else if (wdog != 8'hFF) begin
            wdog <= wdog + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_stb_o  = 1'b0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    case (state)
      OWN0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        s_stb_o  = m0_stb_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
      end
      OWN1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_stb_o  = m1_stb_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
      end
      default: ;
    endcase
  end

  assign m0_err_o = err0;
  assign m1_err_o = err1;
  assign gnt_o    = {state == OWN1, state == OWN0};

endmodule

// File: tb/tb_vram_wb_arbiter.sv
// Directed and random checks of vram_wb_arbiter against a transfer-level reference model.
module tb_vram_wb_arbiter;
  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic [31:0] m0_adr, m0_wdat, m0_rdat, m1_adr, m1_wdat, m1_rdat;
  logic        m0_we, m0_stb, m0_ack, m0_err, m1_we, m1_stb, m1_ack, m1_err;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic        s_we, s_stb, s_ack;
  logic [1:0]  gnt;

  int total;
  int bad;

  // Reference model: who owns the port, who was served last, how long the owner waited.
  int owner;
  int last;
  int waited;
  int err_pend;

  logic [1:0] exp_q[$];

  vram_wb_arbiter #(.AW(32), .DW(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_we_i(m0_we), .m0_stb_i(m0_stb),
    .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_we_i(m1_we), .m1_stb_i(m1_stb),
    .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_we_o(s_we), .s_stb_o(s_stb),
    .s_dat_i(s_rdat), .s_ack_i(s_ack),
    .gnt_o(gnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner    = -1;
    last     = 1;
    waited   = 0;
    err_pend = -1;
  endtask

  // Compare every output with what the model predicts for the current inputs.
  task automatic check_now();
    logic [1:0]  e_gnt;
    logic        e_stb, e_we, e_ack0, e_ack1;
    logic [31:0] e_adr, e_dat, e_d0, e_d1;
    #1;
    e_gnt = 2'b00; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0;
    e_ack0 = 1'b0; e_ack1 = 1'b0; e_d0 = '0; e_d1 = '0;
    if (owner == 0) begin
      e_gnt = 2'b01; e_stb = m0_stb; e_we = m0_we; e_adr = m0_adr; e_dat = m0_wdat;
      e_ack0 = s_ack; e_d0 = s_rdat;
    end else if (owner == 1) begin
      e_gnt = 2'b10; e_stb = m1_stb; e_we = m1_we; e_adr = m1_adr; e_dat = m1_wdat;
      e_ack1 = s_ack; e_d1 = s_rdat;
    end
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("s_stb", 32'(s_stb), 32'(e_stb));
    chk("s_we", 32'(s_we), 32'(e_we));
    chk("s_adr", s_adr, e_adr);
    chk("s_dat", s_wdat, e_dat);
    chk("m0_ack", 32'(m0_ack), 32'(e_ack0));
    chk("m1_ack", 32'(m1_ack), 32'(e_ack1));
    chk("m0_dat", m0_rdat, e_d0);
    chk("m1_dat", m1_rdat, e_d1);
    chk("m0_err", 32'(m0_err), 32'(err_pend == 0));
    chk("m1_err", 32'(m1_err), 32'(err_pend == 1));
  endtask

  // Advance the model by one clock using the arbitration rules, then clock the DUT.
  task automatic tick();
    logic own_stb;
    own_stb  = (owner == 1) ? m1_stb : m0_stb;
    err_pend = -1;
    if (owner < 0) begin
      if (m0_stb && m1_stb) owner = 1 - last;
      else if (m0_stb)      owner = 0;
      else if (m1_stb)      owner = 1;
      waited = 0;
    end else if (own_stb && s_ack) begin
      last = owner; owner = -1;
    end else if (!own_stb) begin
      last = owner; owner = -1;
    end else if (waited == TIMEOUT - 1) begin
      err_pend = owner; last = owner; owner = -1;
    end else if (waited < 255) begin
      waited++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // driver tasks
  task automatic idle_masters();
    m0_stb = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_wdat = '0;
    m1_stb = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_wdat = '0;
    s_ack  = 1'b0; s_rdat = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_masters();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_now();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int errs;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_masters();
    model_reset();
    @(negedge clk);

    // reset state
    do_reset();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_err", 32'({m0_err, m1_err}), 32'h0);

    // single write from master 0
    m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'h10; m0_wdat = 32'hDEADBEEF; s_ack = 1'b1;
    check_now(); tick();
    check_now();
    chk("wr_gnt", 32'(gnt), 32'h1);
    chk("wr_stb", 32'(s_stb), 32'h1);
    chk("wr_adr", s_adr, 32'h10);
    chk("wr_dat", s_wdat, 32'hDEADBEEF);
    chk("wr_ack", 32'(m0_ack), 32'h1);
    tick();
    m0_stb = 1'b0; m0_we = 1'b0;
    check_now();
    chk("wr_idle", 32'(gnt), 32'h0);
    tick();

    // simultaneous requests alternate 0,1,0,1
    do_reset();
    exp_q = {2'b01, 2'b10, 2'b01, 2'b10};
    m0_stb = 1'b1; m1_stb = 1'b1; m0_adr = 32'h100; m1_adr = 32'h200; s_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_now();
      if (gnt != 2'b00 && exp_q.size() > 0) chk("rr_order", 32'(gnt), 32'(exp_q.pop_front()));
      tick();
    end
    chk("rr_count", 32'(exp_q.size()), 32'h0);

    // read routing to master 1
    do_reset();
    m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 32'h24; s_rdat = 32'h12345678; s_ack = 1'b1;
    check_now(); tick();
    check_now();
    chk("rd_dat1", m1_rdat, 32'h12345678);
    chk("rd_ack1", 32'(m1_ack), 32'h1);
    chk("rd_ack0", 32'(m0_ack), 32'h0);
    chk("rd_dat0", m0_rdat, 32'h0);
    tick();
    m1_stb = 1'b0;
    check_now(); tick();

    // watchdog timeout with master 1 waiting
    do_reset();
    m0_stb = 1'b1; m1_stb = 1'b1; m0_adr = 32'h40; m1_adr = 32'h80; s_ack = 1'b0;
    errs = 0;
    for (int i = 0; i < 19; i++) begin
      check_now();
      errs += int'(m0_err);
      if (i == 17) begin
        chk("to_err", 32'(m0_err), 32'h1);
        chk("to_idle", 32'(gnt), 32'h0);
      end
      if (i == 18) chk("to_next", 32'(gnt), 32'h2);
      tick();
    end
    chk("to_pulses", 32'(errs), 32'h1);
    m0_stb = 1'b0; m1_stb = 1'b0;
    check_now(); tick();

    // master 1 abandons, next tie goes to master 0
    do_reset();
    m1_stb = 1'b1; m1_adr = 32'h300;
    check_now(); tick();
    for (int i = 0; i < 3; i++) begin check_now(); tick(); end
    m1_stb = 1'b0;
    check_now(); tick();
    m0_stb = 1'b1; m1_stb = 1'b1;
    check_now();
    chk("ab_noerr", 32'({m0_err, m1_err}), 32'h0);
    chk("ab_noack", 32'({m0_ack, m1_ack}), 32'h0);
    tick();
    check_now();
    chk("ab_tie", 32'(gnt), 32'h1);
    tick();

    // asynchronous reset during OWN0
    do_reset();
    m0_stb = 1'b1; m0_adr = 32'h500;
    check_now(); tick();
    check_now();
    #1 rst = 1'b1;
    #1;
    chk("ar_stb", 32'(s_stb), 32'h0);
    chk("ar_gnt", 32'(gnt), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m1_stb = 1'b1;
    check_now(); tick();
    check_now();
    chk("ar_tie", 32'(gnt), 32'h1);
    tick();

    // random traffic
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if (m0_stb) m0_stb = ($urandom_range(0, 9) != 0);
      else begin
        m0_stb = ($urandom_range(0, 2) == 0);
        m0_adr = $urandom; m0_wdat = $urandom; m0_we = 1'($urandom_range(0, 1));
      end
      if (m1_stb) m1_stb = ($urandom_range(0, 9) != 0);
      else begin
        m1_stb = ($urandom_range(0, 2) == 0);
        m1_adr = $urandom; m1_wdat = $urandom; m1_we = 1'($urandom_range(0, 1));
      end
      s_ack  = ($urandom_range(0, 1) == 1);
      s_rdat = $urandom;
      check_now();
      tick();
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
